ser_port_sched: RTL
===================

Name: ser_port_sched

Overview:
- Schedules ownership of the single cartridge UART between the MIDI port and the RS232 port.
- Replaces the raw combinational serial mux. A port-select request from the control register takes effect only at a line-idle boundary, so no frame is truncated on either port.
- A guard interval with both UART-facing lines held at mark follows each switch.
- Sits between the UART TX/RX pins and the MIDI/RS232 line drivers/receivers.

Parameters:
- IDLE_CYCLES, 1024, consecutive clocks both active lines must be mark (1) before a switch may start.
- GUARD_CYCLES, 16, clocks the UART rxd and the newly selected txd are forced to mark after a switch.
- DRAIN_TIMEOUT, 65535, maximum clocks spent waiting for idle before the switch is forced.

Ports:
- clock  input  1  system clock
- reset  input  1  reset
- sel_req  input  1  requested port from control register; 0=MIDI, 1=RS232
- txd  input  1  UART transmit output
- rxd  output  1  UART receive input
- midi_rxd  input  1  MIDI receive line, asynchronous
- midi_txd  output  1  MIDI transmit line
- rs232_rxd  input  1  RS232 receive line, asynchronous
- rs232_txd  output  1  RS232 transmit line
- ser_sel  output  1  currently granted port; 0=MIDI, 1=RS232
- switching  output  1  high while a switch is pending or in guard
- drain_timeout  output  1  one-clock pulse when a switch was forced by timeout

Interface rules:
- One clock, `clock`. Reset `reset` is synchronous and active-high.
- All state updates occur on the rising edge of `clock`.

Behaviour:
- Synchronisers: midi_rxd and rs232_rxd each pass through a 2-flop synchroniser reset to 1. The idle detector uses only the synchronised values.
- Active rx: act_rx = ser_sel ? rs232_rxd_s : midi_rxd_s.
- Idle counter, width clog2(IDLE_CYCLES+1):
  - Cleared to 0 on any clock where txd==0 or act_rx==0.
  - Otherwise increments, saturating at IDLE_CYCLES.
  - Runs in all states. `idle` = (count==IDLE_CYCLES).
- States: RUN, DRAIN, GUARD.
- RUN:
  - If sel_req != ser_sel, go to DRAIN next clock. The drain counter is cleared and `target` latches sel_req.
- DRAIN:
  - If sel_req == ser_sel (request withdrawn), return to RUN; ser_sel unchanged.
  - Else if idle, go to GUARD and clear the guard counter.
  - Else if the drain counter reaches DRAIN_TIMEOUT, go to GUARD and pulse drain_timeout for exactly one clock.
  - Withdrawal has priority over idle; idle has priority over timeout on the same clock.
  - A sel_req toggle seen in DRAIN only updates `target`.
- GUARD:
  - On entry, ser_sel <= target.
  - sel_req changes are ignored.
  - After GUARD_CYCLES clocks, go to RUN.
  - If sel_req != ser_sel at that point, RUN enters DRAIN on the following clock (normal rule).
- switching = (state != RUN), registered.
- Output mux, combinational from registered state:
  - rxd = GUARD ? 1 : (ser_sel ? rs232_rxd : midi_rxd). Raw line in RUN/DRAIN; adds no latency to received data.
  - midi_txd = (ser_sel==0 && state!=GUARD) ? txd : 0. Inactive or guarded MIDI is driven 0 (current-loop LED off).
  - rs232_txd = (ser_sel==1 && state!=GUARD) ? txd : idle_rs232. idle_rs232 is defined under the optional feature.
- Reset values:
  - state=RUN, ser_sel=0, target=0, idle count=0, drain count=0, guard count=0.
  - Synchronisers=1, switching=0, drain_timeout=0.
- Reset mid-switch: any state returns to RUN with ser_sel=0 on the next edge. A pending request is dropped; it is re-evaluated from sel_req afterwards.
- Counters never wrap: idle saturates; drain and guard counters are cleared on state entry.

Optional Feature:
- Macro: SER_ECHO_EN.
- Defined: idle_rs232 = rs232_rxd. The non-selected RS232 port echoes its own receive line (loopback for terminal test); in GUARD it is held at 1.
- Undefined: idle_rs232 = 1. RS232 txd rests at mark whenever not selected.

Test Plan:
(Bench uses IDLE_CYCLES=8, GUARD_CYCLES=4, DRAIN_TIMEOUT=64.)
1. Reset, lines at 1, sel_req=1 at t0 → DRAIN at t0+1; GUARD once idle counter hits 8; ser_sel=1 on GUARD entry; rxd=1 for 4 clocks; RUN; switching low.
2. sel_req=1 while txd toggles 0/1 every 5 clocks → ser_sel stays 0 and the counter never reaches 8. At drain count 64, drain_timeout pulses exactly once and ser_sel=1 after the GUARD entry edge.
3. sel_req=1 then back to 0 after 3 clocks of DRAIN, with the line busy → return to RUN; ser_sel=0; no GUARD; drain_timeout=0.
4. sel_req toggled during GUARD → ignored. After GUARD, if sel_req != ser_sel, DRAIN starts on the next clock.
5. Assert reset in the 2nd GUARD clock → next edge: state RUN, ser_sel=0, switching=0, midi_txd follows txd.
6. MIDI selected, rs232_rxd pattern 1,0,1 → rs232_txd mirrors the pattern with SER_ECHO_EN, stays 1 without it; midi_txd==txd in both builds.

Source files
------------

// File: rtl/ser_port_sched_if.sv
// Serial port scheduler signal bundle: UART side, MIDI/RS232 line side and status.
// The master modport is the surrounding system; the slave modport is the scheduler.
interface ser_port_sched_if;
    logic sel_req;
    logic txd;
    logic rxd;
    logic midi_rxd;
    logic midi_txd;
    logic rs232_rxd;
    logic rs232_txd;
    logic ser_sel;
    logic switching;
    logic drain_timeout;

    modport master (
        output sel_req, txd, midi_rxd, rs232_rxd,
        input  rxd, midi_txd, rs232_txd, ser_sel, switching, drain_timeout
    );

    modport slave (
        input  sel_req, txd, midi_rxd, rs232_rxd,
        output rxd, midi_txd, rs232_txd, ser_sel, switching, drain_timeout
    );
endinterface

// File: rtl/ser_port_sched.sv
// Hands the single cartridge UART between the MIDI and RS232 ports only at line-idle boundaries.
// Optional macro SER_ECHO_EN: a deselected RS232 port echoes its own receive line on its transmit line.
module ser_port_sched #(
    parameter int IDLE_CYCLES   = 1024,
    parameter int GUARD_CYCLES  = 16,
    parameter int DRAIN_TIMEOUT = 65535
) (
    input logic             clock,
    input logic             reset,
    ser_port_sched_if.slave bus
);
    localparam int IDLE_W  = $clog2(IDLE_CYCLES + 1);
    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, GUARD} state_t;

    state_t             state;
    logic               ser_sel;
    logic               target;
    logic               switching;
    logic               drain_timeout;
    logic               midi_s1, midi_s2;
    logic               rs232_s1, rs232_s2;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [GUARD_W-1:0] guard_cnt;
    logic               act_rx;
    logic               idle;
    logic               in_guard;
    logic               idle_rs232;

    always_ff @(posedge clock) begin
        if (reset) begin
            midi_s1  <= 1'b1;
            midi_s2  <= 1'b1;
            rs232_s1 <= 1'b1;
            rs232_s2 <= 1'b1;
        end else begin
            midi_s1  <= bus.midi_rxd;
            midi_s2  <= midi_s1;
            rs232_s1 <= bus.rs232_rxd;
            rs232_s2 <= rs232_s1;
        end
    end

    assign act_rx = ser_sel ? rs232_s2 : midi_s2;
    assign idle   = (idle_cnt == IDLE_W'(IDLE_CYCLES));

    // Any space bit on either active line restarts the idle window.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (!bus.txd || !act_rx) begin
            idle_cnt <= '0;
        end else if (!idle) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            ser_sel       <= 1'b0;
            target        <= 1'b0;
            drain_cnt     <= '0;
            guard_cnt     <= '0;
            switching     <= 1'b0;
            drain_timeout <= 1'b0;
        end else begin
            drain_timeout <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.sel_req != ser_sel) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        target    <= bus.sel_req;
                        switching <= 1'b1;
                    end
                end
                DRAIN: begin
                    target <= bus.sel_req;
                    // Withdrawal beats idle, idle beats timeout.
                    if (bus.sel_req == ser_sel) begin
                        state     <= RUN;
                        switching <= 1'b0;
                    end else if (idle) begin
                        state     <= GUARD;
                        guard_cnt <= '0;
                        ser_sel   <= target;
                    end else if (drain_cnt == DRAIN_W'(DRAIN_TIMEOUT)) begin
                        state         <= GUARD;
                        guard_cnt     <= '0;
                        ser_sel       <= target;
                        drain_timeout <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (guard_cnt == GUARD_W'(GUARD_CYCLES - 1)) begin
                        state     <= RUN;
                        switching <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= RUN;
                    switching <= 1'b0;
                end
            endcase
        end
    end

    assign in_guard = (state == GUARD);

`ifdef SER_ECHO_EN
    assign idle_rs232 = in_guard ? 1'b1 : bus.rs232_rxd;
`else
    assign idle_rs232 = 1'b1;
`endif

    // Received data bypasses the synchronisers so the UART sees no added latency.
    assign bus.rxd           = in_guard ? 1'b1 : (ser_sel ? bus.rs232_rxd : bus.midi_rxd);
    assign bus.midi_txd      = (!ser_sel && !in_guard) ? bus.txd : 1'b0;
    assign bus.rs232_txd     = (ser_sel && !in_guard) ? bus.txd : idle_rs232;
    assign bus.ser_sel       = ser_sel;
    assign bus.switching     = switching;
    assign bus.drain_timeout = drain_timeout;
endmodule
